sram_write_arbiter: RTL
=======================

SRAM_WRITE_ARBITER -- requirements
Module: sram_write_arbiter

Interface
REQ-001 Parameter HALF_LIMIT, default 16'hC800, number of 16-bit halfwords written before the block stops.
REQ-002 Parameter ADDR_W, default 18, SRAM address width.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req0, req1  input  1 each  write request from chaotic-map generator 0 or 1.
REQ-006 data0, data1  input  32 each  IEEE-754 single-precision result from generator 0 or 1; held stable while req is high.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse when that requester's word is fully written.
REQ-008 grant  output  1  index of the requester currently being served.
REQ-009 busy  output  1  high from grant through ack.
REQ-010 done  output  1  sticky; high once HALF_LIMIT halfwords have been written.
REQ-011 databus  output  16  SRAM write data.
REQ-012 addressbus  output  ADDR_W  SRAM halfword address.
REQ-013 ce, oe, lsb, msb, we  output  1 each  SRAM controls, all active-low.
REQ-014 Fixed SRAM controls: ce=0, oe=1, lsb=0, msb=0.

Function
REQ-015 FSM states and transitions:
- IDLE -> LO_SET -> LO_WE -> HI_SET -> HI_WE -> ACK -> IDLE or DONE.
- DONE is terminal.
REQ-016 In IDLE with at least one req high and done low:
- select a requester per REQ-024;
- latch its 32-bit data and set grant;
- go to LO_SET on the next edge.
REQ-017 LO_SET: databus = latched[15:0], addressbus = A, we=1.
REQ-018 LO_WE: databus and address unchanged, we=0 for exactly one cycle.
REQ-019 HI_SET: databus = latched[31:16], addressbus = A+1, we=1.
REQ-020 HI_WE: we=0 for exactly one cycle.
REQ-021 ACK:
- ack[grant]=1 for one cycle;
- A advances by 2;
- write counter advances by 2.
REQ-022 Latency: ack is asserted exactly 5 cycles after the IDLE cycle that granted the request. The next grant is possible in the cycle after ACK.
REQ-023 Address and data never change while we=0. Address wraps modulo 2^ADDR_W.
REQ-024 Arbitration: when only one req is high, that requester is served. When both are high, the choice is set by ROUND_ROBIN_EN.
REQ-025 Requester timing:
- A req deasserted after grant does not abort the transfer; ack is still pulsed.
- A req deasserted before grant is ignored.
REQ-026 In ACK, when the counter reaches or exceeds HALF_LIMIT, go to DONE. done=1 from the following cycle.
REQ-027 DONE behaviour:
- we=1, no further acks, reqs ignored;
- databus and addressbus hold their last values.
REQ-028 The latched word is only captured in IDLE; changes on data0/data1 mid-transfer have no effect.

Reset
REQ-029 While reset=0, asynchronously force:
- state IDLE;
- A=0, counter=0;
- ack0=ack1=0, busy=0, done=0, grant=0;
- databus=0, addressbus=0, we=1;
- round-robin pointer to favour requester 0.
REQ-030 Reset asserted mid-transfer aborts it immediately with no ack. After release, writing restarts at address 0.
REQ-031 Reset release takes effect on the first rising clk edge after reset returns high.

Configuration
REQ-032 Macro ROUND_ROBIN_EN, defined: on simultaneous requests, grant the requester not served most recently. The pointer updates in ACK.
REQ-033 Macro ROUND_ROBIN_EN, undefined: fixed priority; requester 0 always wins on simultaneous requests.

Verification
REQ-034 Single write: req0=1, data0=32'h3DCCCCCD from reset -> we low at addr 0 with data 16'hCCCD, then at addr 1 with data 16'h3DCC; ack0 five cycles after grant.
REQ-035 Contention: req0=req1=1 held for 4 words -> with ROUND_ROBIN_EN, grant sequence 0,1,0,1 and addresses 0,2,4,6; without it, grant 0,0,0,0.
REQ-036 Limit: HALF_LIMIT=8, req1 held high -> exactly 4 ack1 pulses; done=1 after the 4th; we stays 1 afterwards.
REQ-037 Reset mid-op: drop reset during LO_WE -> we=1 and outputs at reset values within the same cycle; no ack; next write at addr 0.
REQ-038 Withdrawn request: req0 dropped one cycle after grant -> transfer completes, ack0 pulses, data written equals the value latched at grant.
REQ-039 Address wrap: ADDR_W=3, HALF_LIMIT=16, req0 held high -> addresses 0..7 then 0..7 again; done after 8 acks.

Source files
------------

// File: rtl/sram_write_arbiter.sv
// Arbitrates two 32-bit float producers onto a 16-bit async SRAM, writing each word as two halfwords.
// Optional macro ROUND_ROBIN_EN: alternate between requesters on contention instead of fixed priority to requester 0.
module sram_write_arbiter #(
   parameter logic [15:0] HALF_LIMIT = 16'hC800,
   parameter int          ADDR_W     = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic [31:0]       data0,
   input  logic [31:0]       data1,
   output logic              ack0,
   output logic              ack1,
   output logic              grant,
   output logic              busy,
   output logic              done,
   output logic [15:0]       databus,
   output logic [ADDR_W-1:0] addressbus,
   output logic              ce,
   output logic              oe,
   output logic              lsb,
   output logic              msb,
   output logic              we
);

   typedef enum logic [2:0] {
      IDLE,
      LO_SET,
      LO_WE,
      HI_SET,
      HI_WE,
      ACK,
      DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [15:0]       hi_half;
   logic [ADDR_W-1:0] base_addr;
   logic [16:0]       half_cnt;
   logic [16:0]       cnt_after;
   logic              limit_hit;
   logic              any_req;
   logic              pick;
   logic              grant_q;

   assign ce  = 1'b0;
   assign oe  = 1'b1;
   assign lsb = 1'b0;
   assign msb = 1'b0;

   assign any_req   = req0 | req1;
   assign cnt_after = half_cnt + 17'd2;
   assign limit_hit = (cnt_after >= {1'b0, HALF_LIMIT});

`ifdef ROUND_ROBIN_EN
   // prefer names the requester that wins the next tie; it flips to the other side after each ack
   logic prefer;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prefer <= 1'b0;
      end else if (state == ACK) begin
         prefer <= ~grant_q;
      end
   end

   always_comb begin
      pick = 1'b0;
      if (req0 && req1) begin
         pick = prefer;
      end else begin
         pick = req1;
      end
   end
`else
   always_comb begin
      pick = 1'b0;
      if (!req0) begin
         pick = req1;
      end
   end
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_req) state_next = LO_SET;
         LO_SET:  state_next = LO_WE;
         LO_WE:   state_next = HI_SET;
         HI_SET:  state_next = HI_WE;
         HI_WE:   state_next = ACK;
         ACK:     state_next = limit_hit ? DONE : IDLE;
         DONE:    state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      we    = 1'b1;
      ack0  = 1'b0;
      ack1  = 1'b0;
      busy  = 1'b0;
      done  = 1'b0;
      grant = grant_q;
      case (state)
         LO_SET, HI_SET: busy = 1'b1;
         LO_WE, HI_WE: begin
            busy = 1'b1;
            we   = 1'b0;
         end
         ACK: begin
            busy = 1'b1;
            ack0 = ~grant_q;
            ack1 = grant_q;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   // Bus registers only load on the edges entering LO_SET and HI_SET, so they are stable across every we-low cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         hi_half    <= '0;
         base_addr  <= '0;
         half_cnt   <= '0;
         grant_q    <= 1'b0;
         databus    <= '0;
         addressbus <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_q    <= pick;
                  hi_half    <= pick ? data1[31:16] : data0[31:16];
                  databus    <= pick ? data1[15:0] : data0[15:0];
                  addressbus <= base_addr;
               end
            end
            LO_WE: begin
               databus    <= hi_half;
               addressbus <= base_addr + ADDR_W'(1);
            end
            ACK: begin
               base_addr <= base_addr + ADDR_W'(2);
               half_cnt  <= cnt_after;
            end
            default: ;
         endcase
      end
   end

endmodule
